// File: rtl/cmd_frame_parser_pkg.sv
// Shared definitions for the host command-frame decoder and its consumers:
// FSM state encoding, abort cause codes and default framing bytes.
package cmd_frame_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_DAT0,
    ST_DATA,
    ST_CHK,
    ST_TRL
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TRL     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEF_HDR_BYTE = 8'hAA;
  localparam logic [7:0] DEF_TRL_BYTE = 8'h55;

endpackage

// File: rtl/cmd_frame_parser_timeout.sv
// Inter-byte timeout: free-running counter with synchronous clear and an
// expiry flag raised while the count sits at TIMEOUT_CYC-1.
module frame_timeout #(
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/cmd_frame_parser.sv
// Host command-frame decoder: HDR, SEL, [payload, [XOR checksum]], TRL.
// Decoded fields are published atomically with a one-cycle frame_done pulse.
module cmd_frame_parser
  import cmd_frame_parser_pkg::*;
#(
  parameter int unsigned IN_BYTES    = 2,
  parameter logic [7:0]  HDR_BYTE    = DEF_HDR_BYTE,
  parameter logic [7:0]  TRL_BYTE    = DEF_TRL_BYTE,
  parameter bit          CHK_EN      = 1'b0,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic                  tclk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            exp_sel,
  output logic [8*IN_BYTES-1:0] logic_in,
  output logic                  key_mode,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [1:0]            err_code
);

  localparam int unsigned PW = 8 * IN_BYTES;
  localparam int unsigned IW = $clog2(IN_BYTES) + 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(IN_BYTES - 1);
  localparam state_t ST_POST = CHK_EN ? ST_CHK : ST_TRL;

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [PW-1:0]   shadow, shadow_n;
  logic [7:0]      sel_sh, sel_sh_n;
  logic [7:0]      run_xor, run_xor_n;
  logic [7:0]      exp_sel_n;
  logic [PW-1:0]   logic_in_n;
  logic            key_mode_n, frame_done_n, frame_err_n;
  logic [1:0]      err_code_n;
  logic            expired;

  frame_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (tclk),
    .rst    (rst),
    .clr    (rx_valid || (state == ST_IDLE)),
    .en     (1'b1),
    .expired(expired)
  );

  always_ff @(posedge tclk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      shadow     <= '0;
      sel_sh     <= '0;
      run_xor    <= '0;
      exp_sel    <= '0;
      logic_in   <= '0;
      key_mode   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      shadow     <= shadow_n;
      sel_sh     <= sel_sh_n;
      run_xor    <= run_xor_n;
      exp_sel    <= exp_sel_n;
      logic_in   <= logic_in_n;
      key_mode   <= key_mode_n;
      frame_done <= frame_done_n;
      frame_err  <= frame_err_n;
      err_code   <= err_code_n;
    end
  end

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    shadow_n     = shadow;
    sel_sh_n     = sel_sh;
    run_xor_n    = run_xor;
    exp_sel_n    = exp_sel;
    logic_in_n   = logic_in;
    key_mode_n   = key_mode;
    frame_done_n = 1'b0;
    frame_err_n  = 1'b0;
    err_code_n   = err_code;

    if (rx_valid) begin
      unique case (state)
        ST_IDLE: begin
          if (rx_data == HDR_BYTE) state_n = ST_SEL;
        end
        ST_SEL: begin
          sel_sh_n  = rx_data;
          run_xor_n = rx_data;
          state_n   = ST_DAT0;
        end
        ST_DAT0: begin
          if (rx_data == TRL_BYTE) begin
            exp_sel_n    = sel_sh;
            key_mode_n   = 1'b1;
            frame_done_n = 1'b1;
            state_n      = ST_IDLE;
          end else begin
            // Payload is shifted in from the LSB so the first byte ends up as MSB.
            shadow_n  = PW'(rx_data);
            run_xor_n = run_xor ^ rx_data;
            idx_n     = IW'(1);
            state_n   = (IN_BYTES == 1) ? ST_POST : ST_DATA;
          end
        end
        ST_DATA: begin
          shadow_n  = (shadow << 8) | PW'(rx_data);
          run_xor_n = run_xor ^ rx_data;
          idx_n     = idx + IW'(1);
          if (idx == IDX_LAST) state_n = ST_POST;
        end
        ST_CHK: begin
          if (rx_data == run_xor) begin
            state_n = ST_TRL;
          end else begin
            frame_err_n = 1'b1;
            err_code_n  = ERR_CHK;
            state_n     = ST_IDLE;
          end
        end
        ST_TRL: begin
          if (rx_data == TRL_BYTE) begin
            exp_sel_n    = sel_sh;
            logic_in_n   = shadow;
            key_mode_n   = 1'b0;
            frame_done_n = 1'b1;
          end else begin
            frame_err_n = 1'b1;
            err_code_n  = ERR_TRL;
          end
          state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end else if ((state != ST_IDLE) && expired) begin
      frame_err_n = 1'b1;
      err_code_n  = ERR_TIMEOUT;
      state_n     = ST_IDLE;
    end

    if (state_n == ST_IDLE) begin
      idx_n     = '0;
      run_xor_n = '0;
    end
  end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed bench: dut0 runs without checksum, dut1 with checksum; both
// use a short inter-byte timeout so expiry can be exercised.
module tb_cmd_frame_parser;

  logic        tclk = 1'b0;
  logic        rst  = 1'b1;
  logic [7:0]  rxd0 = '0, rxd1 = '0;
  logic        rxv0 = 1'b0, rxv1 = 1'b0;

  logic [7:0]  exp_sel0, exp_sel1;
  logic [15:0] logic_in0, logic_in1;
  logic        key_mode0, key_mode1;
  logic        done0, done1, err0, err1;
  logic [1:0]  code0, code1;

  int checks = 0;
  int errors = 0;

  always #5 tclk = ~tclk;

  cmd_frame_parser #(
    .IN_BYTES(2), .HDR_BYTE(8'hAA), .TRL_BYTE(8'h55), .CHK_EN(1'b0), .TIMEOUT_CYC(20)
  ) dut0 (
    .tclk(tclk), .rst(rst), .rx_data(rxd0), .rx_valid(rxv0),
    .exp_sel(exp_sel0), .logic_in(logic_in0), .key_mode(key_mode0),
    .frame_done(done0), .frame_err(err0), .err_code(code0)
  );

  cmd_frame_parser #(
    .IN_BYTES(2), .HDR_BYTE(8'hAA), .TRL_BYTE(8'h55), .CHK_EN(1'b1), .TIMEOUT_CYC(20)
  ) dut1 (
    .tclk(tclk), .rst(rst), .rx_data(rxd1), .rx_valid(rxv1),
    .exp_sel(exp_sel1), .logic_in(logic_in1), .key_mode(key_mode1),
    .frame_done(done1), .frame_err(err1), .err_code(code1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe one byte; returns on the falling edge just after it was consumed.
  task automatic send(input int which, input logic [7:0] b);
    @(negedge tclk);
    if (which == 0) begin rxd0 = b; rxv0 = 1'b1; end
    else            begin rxd1 = b; rxv1 = 1'b1; end
    @(negedge tclk);
    rxv0 = 1'b0;
    rxv1 = 1'b0;
  endtask

  task automatic chk0(input string tag, input logic d, input logic e, input logic [7:0] s,
                      input logic [15:0] li, input logic k);
    chk({tag, "_done"}, 64'(done0), 64'(d));
    chk({tag, "_err"},  64'(err0),  64'(e));
    chk({tag, "_sel"},  64'(exp_sel0), 64'(s));
    chk({tag, "_li"},   64'(logic_in0), 64'(li));
    chk({tag, "_km"},   64'(key_mode0), 64'(k));
  endtask

  task automatic chk1(input string tag, input logic d, input logic e, input logic [7:0] s,
                      input logic [15:0] li, input logic k);
    chk({tag, "_done"}, 64'(done1), 64'(d));
    chk({tag, "_err"},  64'(err1),  64'(e));
    chk({tag, "_sel"},  64'(exp_sel1), 64'(s));
    chk({tag, "_li"},   64'(logic_in1), 64'(li));
    chk({tag, "_km"},   64'(key_mode1), 64'(k));
  endtask

  initial begin
    repeat (3) @(negedge tclk);
    chk0("rst0", 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    chk1("rst1", 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    chk("rst0_code", 64'(code0), 64'(0));
    rst = 1'b0;

    // Short frame
    send(0, 8'hAA); send(0, 8'h11);
    chk("short_pre_done", 64'(done0), 64'(0));
    send(0, 8'h55);
    chk0("short", 1'b1, 1'b0, 8'h11, 16'h0000, 1'b1);
    @(negedge tclk);
    chk("short_done_fall", 64'(done0), 64'(0));

    // Long frame without checksum; outputs untouched until trailer
    send(0, 8'hAA); send(0, 8'h21); send(0, 8'h12); send(0, 8'h34);
    chk0("long_partial", 1'b0, 1'b0, 8'h11, 16'h0000, 1'b1);
    send(0, 8'h55);
    chk0("long", 1'b1, 1'b0, 8'h21, 16'h1234, 1'b0);
    @(negedge tclk);
    chk("long_done_fall", 64'(done0), 64'(0));

    // Checksum good then bad
    send(1, 8'hAA); send(1, 8'h21); send(1, 8'h12); send(1, 8'h34); send(1, 8'h07);
    chk("chk_ok_pre", 64'(done1), 64'(0));
    send(1, 8'h55);
    chk1("chk_ok", 1'b1, 1'b0, 8'h21, 16'h1234, 1'b0);
    send(1, 8'hAA); send(1, 8'h22); send(1, 8'h56); send(1, 8'h78); send(1, 8'h08);
    chk1("chk_bad", 1'b0, 1'b1, 8'h21, 16'h1234, 1'b0);
    chk("chk_bad_code", 64'(code1), 64'(2));
    send(1, 8'h55);
    chk1("chk_trail_ignored", 1'b0, 1'b0, 8'h21, 16'h1234, 1'b0);
    chk("chk_code_hold", 64'(code1), 64'(2));

    // Noise then bad trailer, then a good frame
    send(0, 8'h00); send(0, 8'h7F); send(0, 8'hAA); send(0, 8'h31);
    send(0, 8'hAB); send(0, 8'hCD); send(0, 8'h66);
    chk0("bad_trl", 1'b0, 1'b1, 8'h21, 16'h1234, 1'b0);
    chk("bad_trl_code", 64'(code0), 64'(1));
    @(negedge tclk);
    chk("bad_trl_err_fall", 64'(err0), 64'(0));
    send(0, 8'hAA); send(0, 8'h31); send(0, 8'hAB); send(0, 8'hCD); send(0, 8'h55);
    chk0("resync", 1'b1, 1'b0, 8'h31, 16'hABCD, 1'b0);
    chk("resync_code_hold", 64'(code0), 64'(1));

    // Timeout fires after the counter has sat at 19
    send(0, 8'hAA); send(0, 8'h11);
    for (int i = 0; i < 19; i++) begin
      @(negedge tclk);
      chk("to_quiet", 64'(err0), 64'(0));
    end
    @(negedge tclk);
    chk0("timeout", 1'b0, 1'b1, 8'h31, 16'hABCD, 1'b0);
    chk("timeout_code", 64'(code0), 64'(3));

    // Byte on the expiry cycle wins over the timeout
    send(0, 8'hAA); send(0, 8'h11);
    repeat (19) @(negedge tclk);
    rxd0 = 8'h12; rxv0 = 1'b1;
    @(negedge tclk);
    rxv0 = 1'b0;
    chk("to_suppressed", 64'(err0), 64'(0));
    send(0, 8'h34); send(0, 8'h55);
    chk0("to_suppressed_frame", 1'b1, 1'b0, 8'h11, 16'h1234, 1'b0);

    // Reset mid-frame
    send(0, 8'hAA); send(0, 8'h41); send(0, 8'h12);
    rst = 1'b1;
    @(negedge tclk);
    rst = 1'b0;
    chk0("midrst", 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    chk("midrst_code", 64'(code0), 64'(0));
    send(0, 8'hAA); send(0, 8'h41); send(0, 8'h55);
    chk0("post_rst", 1'b1, 1'b0, 8'h41, 16'h0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
